sigmoid_table_loader: RTL
=========================

# sigmoid_table_loader

Runtime writer for the sigmoid lookup memory. It accepts a stream of precomputed activation samples over a valid/ready handshake and drives the write port of the sigmoid table RAM, so the table can be replaced without re-synthesis. Its address order matches the offset-binary indexing used by the table's read side. It sits between the host/config interface and the sigmoid memory in each neuron's activation path.

## Interface

- inWidth, default 5: table index width; the table holds 2**inWidth entries.
- dataWidth, default 16: sample word width.

- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a table load; honoured only in IDLE or DONE.
- abort  input  1  terminates a load in progress.
- wr_valid  input  1  a sample beat is present.
- wr_data  input  dataWidth  sample value.
- wr_ready  output  1  loader accepts a beat.
- mem_we  output  1  table write enable; registered.
- mem_addr  output  inWidth  table write address; registered.
- mem_wdata  output  dataWidth  table write data; registered.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  load finished; held until the next start or rst.
- err  output  1  abort or checksum failure; held until the next start or rst.

## Operation

- Reset behaviour: rst forces state IDLE and sets all outputs to 0, including wr_ready. It also clears the address counter and the checksum accumulator. rst overrides every other input.
- State IDLE: wr_ready=0. A start pulse moves the FSM to LOAD, clears the counter, done, err and the accumulator.
- State LOAD:
  - wr_ready=1.
  - On each handshake (wr_valid && wr_ready), the loader writes wr_data to address = counter, then increments the counter.
  - Beat k (counter value k) is the sample for signed input k − 2**(inWidth−1). Beat 0 is the most negative input, so address equals beat number.
  - After the handshake at counter = 2**inWidth−1, the FSM goes to CHECK if SIGMOID_LOAD_CHECKSUM_EN is defined, otherwise to DONE. The counter wraps to 0 and is not reused.
- State CHECK: wr_ready=1. Exactly one beat is accepted. It is compared with the accumulator; on mismatch, err=1. No memory write occurs. The FSM then goes to DONE.
- State DONE: done=1, busy=0, wr_ready=0. start re-enters LOAD and clears done and err.
- Start handling: start in LOAD or CHECK is ignored.
- Abort: abort in LOAD or CHECK returns the FSM to IDLE with err=1 and done=0.
  - abort has priority over a same-cycle handshake: that beat is discarded and no write is issued.
  - Entries already written stay in the table.
  - abort in IDLE or DONE is ignored.
- Flow control: wr_valid gaps of any length are allowed. Beats are never dropped or duplicated.

## Timing

- start at cycle t: busy=1 and wr_ready=1 from t+1.
- Handshake at cycle c: mem_we=1 with mem_addr/mem_wdata valid at c+1 only. mem_we=0 in every other cycle.
- Last sample beat at cycle L, checksum macro absent: the last write and done=1/busy=0 are all visible at L+1.
- Checksum beat at cycle C, macro present: done=1, busy=0 and the final err are visible at C+1.
- abort at cycle a: busy=0, err=1 and wr_ready=0 at a+1.
- Back-to-back: throughput is one beat per cycle. A full load takes at least 2**inWidth cycles, plus 1 when the checksum is enabled.

## Configuration

- SIGMOID_LOAD_CHECKSUM_EN defined:
  - The accumulator sums all 2**inWidth accepted sample words modulo 2**dataWidth.
  - The CHECK state expects one trailing beat carrying that sum. A mismatch sets err while done still asserts.
- Macro absent: there is no accumulator and no CHECK state, and the load ends at the last sample. err is set only by abort.

## Test plan

- Reset, start, then stream 32 beats with wr_data = k·0x0800 and wr_valid held high: 32 writes at addr k with data k·0x0800 on consecutive cycles; done=1 one cycle after the last beat; err=0.
- Same load with wr_valid toggling every cycle: still 32 writes, contiguous addresses 0..31, no duplicates; done after the 32nd beat.
- abort asserted in the same cycle as beat 10 (after 10 accepted beats): exactly 10 writes (addr 0..9), no write for beat 10; err=1, busy=0, done=0 next cycle.
- start pulses during LOAD are ignored (counter unaffected); start from DONE clears done/err next cycle and the following load rewrites from addr 0.
- With SIGMOID_LOAD_CHECKSUM_EN, all samples 0x0001: trailing 0x0020 gives err=0, done=1; trailing 0x0021 gives err=1, done=1, and no 33rd write.
- rst asserted mid-load at beat 15: the next cycle shows all outputs 0 and state IDLE; a fresh start reloads from addr 0.

Source files
------------

// File: rtl/sigmoid_table_loader.sv
// Streams sample beats into the sigmoid table RAM write port.
// Define SIGMOID_LOAD_CHECKSUM_EN to require a trailing checksum beat.
module sigmoid_table_loader #(
  parameter int inWidth   = 5,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 wr_valid,
  input  logic [dataWidth-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 mem_we,
  output logic [inWidth-1:0]   mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [inWidth-1:0] CNT_ONE  = inWidth'(1);
  localparam logic [inWidth-1:0] CNT_LAST = {inWidth{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [inWidth-1:0]   cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [inWidth-1:0]   addr_q, addr_d;
  logic [dataWidth-1:0] wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 hs;

`ifdef SIGMOID_LOAD_CHECKSUM_EN
  logic [dataWidth-1:0] acc_q, acc_d;
`endif

  assign wr_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign busy      = wr_ready;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign hs        = wr_valid && wr_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        // abort wins over a same-cycle beat: nothing is written
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (hs) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = wr_data;
          cnt_d   = cnt_q + CNT_ONE;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
          acc_d   = acc_q + wr_data;
          if (cnt_q == CNT_LAST) state_d = S_CHECK;
`else
          if (cnt_q == CNT_LAST) state_d = S_DONE;
`endif
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (hs) begin
          state_d = S_DONE;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
          if (wr_data != acc_q) err_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef SIGMOID_LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`endif

endmodule
